mhp_tx_arbiter: RTL

- Round-robin arbiter that shares the single Ethernet transmit byte port (o_wdata / o_wvalid / i_wready) between N frame sources, e.g. the ping responder and the frame assembler.
- Grants the port to one source for one whole frame, delimited by that source's last flag.
- Enforces a maximum frame length and a minimum inter-frame gap.
- Sits between the MHP frame sources and the Ethernet MAC write interface.

---
 rtl/mhp_tx_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mhp_tx_arbiter.sv
// mhp_tx_arbiter: round-robin owner of the single Ethernet transmit byte port.
// One source holds the port for a whole frame, delimited by its last flag.
// Frames are truncated at MAX_LEN bytes, and every frame is followed by GAP
// idle cycles. The byte path from the granted source to the MAC is purely
// combinational, so it adds no latency.
module mhp_tx_arbiter #(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned GAP     = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [8*N_REQ-1:0] i_data,
   input  logic [N_REQ-1:0]   i_valid,
   input  logic [N_REQ-1:0]   i_last,
   output logic [N_REQ-1:0]   o_gnt,
   output logic [N_REQ-1:0]   o_ready,
   output logic [7:0]         o_wdata,
   input  logic               i_wready,
   output logic               o_wvalid,
   output logic               o_busy,
   output logic               o_abort
);

   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CntW = $clog2(MAX_LEN + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(MAX_LEN - 1);
   localparam logic [3:0] GapLoad = 4'(GAP);

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StXfer,
      StGap
   } state_e;

   state_e            state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [3:0]        gap_q, gap_d;
   logic              abort_q, abort_d;

   logic              sel_hit;
   logic [IdxW-1:0]   sel_idx;
   logic [7:0]        cur_data;
   logic              cur_valid;
   logic              cur_last;
   logic              cur_req;
   logic              in_xfer;
   logic              fire;
   logic              at_max;
   logic              frame_end;
   logic              trunc;

   // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (i_req[k]) begin
            sel_hit = 1'b1;
            sel_idx = IdxW'(k);
         end
      end
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (i_req[k] && (k >= int'(ptr_q))) begin
            sel_idx = IdxW'(k);
         end
      end
   end

   // Select the granted source's signals with a one-hot AND-OR mux.
   always_comb begin
      cur_data  = '0;
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      cur_req   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt_q[k]) begin
            cur_data  = cur_data | i_data[8*k +: 8];
            cur_valid = cur_valid | i_valid[k];
            cur_last  = cur_last | i_last[k];
            cur_req   = cur_req | i_req[k];
         end
      end
   end

   // Decode frame termination events for the current transfer cycle.
   always_comb begin
      in_xfer   = (state_q == StXfer);
      fire      = in_xfer & cur_valid & i_wready;
      at_max    = (cnt_q == LastCnt);
      // The last flag wins over truncation when both land on the same byte.
      trunc     = fire & ~cur_last & at_max;
      frame_end = (fire & (cur_last | at_max)) | (in_xfer & ~fire & ~cur_req);
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (sel_hit) begin
               state_d = StGrant;
            end
         end
         StGrant: begin
            state_d = StXfer;
         end
         StXfer: begin
            if (frame_end) begin
               state_d = (GAP == 0) ? StIdle : StGap;
            end
         end
         StGap: begin
            if (gap_q <= 4'd1) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Next values for grant, pointer, byte counter, gap counter and abort pulse.
   always_comb begin
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      abort_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sel_hit) begin
               gnt_d = N_REQ'(1) << sel_idx;
               idx_d = sel_idx;
            end
         end
         StGrant: begin
            cnt_d = '0;
         end
         StXfer: begin
            if (fire) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (frame_end) begin
               gnt_d   = '0;
               ptr_d   = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
               gap_d   = GapLoad;
               abort_d = trunc;
            end
         end
         StGap: begin
            gnt_d = '0;
            if (gap_q != 4'd0) begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         abort_q <= abort_d;
      end
   end

   // Outputs: the byte path is live only while transferring.
   always_comb begin
      o_ready  = '0;
      o_wdata  = '0;
      o_wvalid = 1'b0;
      o_busy   = (state_q != StIdle);
      if (state_q == StXfer) begin
         o_ready  = gnt_q & {N_REQ{i_wready}};
         o_wdata  = cur_data;
         o_wvalid = cur_valid;
      end
   end

   assign o_gnt   = gnt_q;
   assign o_abort = abort_q;

   // At most one grant, and it never moves while a frame is in flight.
   a_gnt_onehot: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(gnt_q));
   a_gnt_stable: assert property (@(posedge i_clk) disable iff (i_rst)
      (state_q == StXfer && state_d == StXfer) |=> $stable(gnt_q));

endmodule
